// File: rtl/bingo_mark_ctrl_pkg.sv
// Shared definitions for the bingo mark controller.
// Holds the board geometry, the controller FSM state type, the line index
// constants and a helper that returns the 25-bit cell mask of a line.
package bingo_mark_ctrl_pkg;

  localparam int unsigned GRID  = 5;
  localparam int unsigned CELLS = 25;
  localparam int unsigned LINES = 12;

  // Lines 0-4 are rows, 5-9 are columns, 10 is the main diagonal and
  // 11 is the anti-diagonal.
  localparam logic [3:0] LN_ROW0 = 4'd0;
  localparam logic [3:0] LN_COL0 = 4'd5;
  localparam logic [3:0] LN_DIAG = 4'd10;
  localparam logic [3:0] LN_ANTI = 4'd11;
  localparam logic [3:0] LN_LAST = 4'(LINES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    CHECK,
    DONE
  } state_t;

  // Cell i is at x = i % GRID, y = i / GRID. Out-of-range ln gives all zeros.
  function automatic logic [CELLS-1:0] line_mask(input logic [3:0] ln);
    logic [CELLS-1:0] m;
    int unsigned      l;
    m = '0;
    l = {28'd0, ln};
    for (int unsigned i = 0; i < GRID; i++) begin
      if (ln < LN_COL0)       m[l*GRID + i]          = 1'b1;
      else if (ln < LN_DIAG)  m[(l - GRID) + i*GRID] = 1'b1;
      else if (ln == LN_DIAG) m[i*(GRID + 1)]        = 1'b1;
      else if (ln == LN_ANTI) m[(i + 1)*(GRID - 1)]  = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/bingo_mark_ctrl_line_mask.sv
// Combinational line-mask lookup.
// Ports:
//   ln   - line index 0..11 (rows, columns, diagonal, anti-diagonal)
//   mask - 25-bit mask of the cells belonging to that line
module bingo_line_mask
  import bingo_mark_ctrl_pkg::*;
(
  input  logic [3:0]       ln,
  output logic [CELLS-1:0] mask
);

  always_comb mask = line_mask(ln);

endmodule

// File: rtl/bingo_mark_ctrl.sv
// Bingo mark controller: accepts a number to mark, scans the 5x5 board map
// one cell per cycle for it, circles the first matching cell, then recounts
// all fully circled lines one line per cycle and publishes the count, its
// BCD form and the bingo flag.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   clear          - synchronous new-game clear (highest priority)
//   map            - board numbers, cell i at map[i*CELL_W +: CELL_W]
//   mark_num/valid - mark request, accepted while mark_ready is high
//   mark_ready     - high only in IDLE
//   mark_done      - one-cycle completion pulse
//   mark_hit       - last request found its number
//   circle         - circled-cell mask
//   line_cnt       - completed lines 0..12
//   display_nums   - BCD {tens, ones} of line_cnt
//   bingo          - line_cnt >= BINGO_LINES
module bingo_mark_ctrl
  import bingo_mark_ctrl_pkg::*;
#(
  parameter int CELL_W      = 5,
  parameter int BINGO_LINES = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [25*CELL_W-1:0]  map,
  input  logic [CELL_W-1:0]     mark_num,
  input  logic                  mark_valid,
  output logic                  mark_ready,
  output logic                  mark_done,
  output logic                  mark_hit,
  output logic [CELLS-1:0]      circle,
  output logic [3:0]            line_cnt,
  output logic [7:0]            display_nums,
  output logic                  bingo
);

  state_t            state, state_next;
  logic [CELL_W-1:0] num_q;
  logic [4:0]        idx;
  logic [3:0]        ln;
  logic [3:0]        acc;
  logic [CELL_W-1:0] cell_num;
  logic              cell_match;
  logic              last_cell;
  logic [CELLS-1:0]  mask;
  logic              line_full;
  logic [3:0]        cnt_next;
  logic [7:0]        bcd_next;

  bingo_line_mask u_line_mask (
    .ln   (ln),
    .mask (mask)
  );

  always_comb begin
    cell_num   = map[32'(idx)*CELL_W +: CELL_W];
    cell_match = (cell_num == num_q);
    last_cell  = (idx == 5'(CELLS - 1));
    line_full  = ((circle & mask) == mask);
    cnt_next   = acc + {3'd0, line_full};
    bcd_next   = (cnt_next >= 4'd10) ? {4'd1, cnt_next - 4'd10} : {4'd0, cnt_next};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        state <= IDLE;
    else if (clear) state <= IDLE;
    else            state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (mark_valid)              state_next = SCAN;
      SCAN:  if (cell_match || last_cell) state_next = CHECK;
      CHECK: if (ln == LN_LAST)           state_next = DONE;
      DONE:                               state_next = IDLE;
      default:                            state_next = IDLE;
    endcase
  end

  // Outputs; a clear during DONE suppresses the completion pulse
  always_comb begin
    mark_ready = (state == IDLE);
    mark_done  = (state == DONE) && !clear;
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_q        <= '0;
      idx          <= '0;
      ln           <= LN_ROW0;
      acc          <= '0;
      mark_hit     <= 1'b0;
      circle       <= '0;
      line_cnt     <= '0;
      display_nums <= '0;
      bingo        <= 1'b0;
    end else if (clear) begin
      mark_hit     <= 1'b0;
      circle       <= '0;
      line_cnt     <= '0;
      display_nums <= '0;
      bingo        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mark_valid) begin
            num_q <= mark_num;
            idx   <= '0;
          end
        end
        SCAN: begin
          if (cell_match) begin
            circle   <= circle | (CELLS'(1) << idx);
            mark_hit <= 1'b1;
            ln       <= LN_ROW0;
            acc      <= '0;
          end else if (last_cell) begin
            mark_hit <= 1'b0;
            ln       <= LN_ROW0;
            acc      <= '0;
          end else begin
            idx <= idx + 5'd1;
          end
        end
        CHECK: begin
          if (ln == LN_LAST) begin
            line_cnt     <= cnt_next;
            display_nums <= bcd_next;
            bingo        <= (int'(cnt_next) >= BINGO_LINES);
          end else begin
            acc <= cnt_next;
            ln  <= ln + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bingo_mark_ctrl.sv
module tb_bingo_mark_ctrl;

  localparam int CW = 5;
  localparam int BL = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           clear;
  logic [25*CW-1:0] map;
  logic [CW-1:0]  mark_num;
  logic           mark_valid;
  logic           mark_ready;
  logic           mark_done;
  logic           mark_hit;
  logic [24:0]    circle;
  logic [3:0]     line_cnt;
  logic [7:0]     display_nums;
  logic           bingo;

  bingo_mark_ctrl #(.CELL_W(CW), .BINGO_LINES(BL)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .map          (map),
    .mark_num     (mark_num),
    .mark_valid   (mark_valid),
    .mark_ready   (mark_ready),
    .mark_done    (mark_done),
    .mark_hit     (mark_hit),
    .circle       (circle),
    .line_cnt     (line_cnt),
    .display_nums (display_nums),
    .bingo        (bingo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        hit;
    logic [24:0] circ;
    logic [3:0]  cnt;
    logic [7:0]  disp;
    logic        bng;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  int          m_map[25];
  logic [24:0] m_circle = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int count_lines(input logic [24:0] c);
    int  n;
    bit  full;
    n = 0;
    for (int y = 0; y < 5; y++) begin
      full = 1;
      for (int x = 0; x < 5; x++) if (!c[x + 5*y]) full = 0;
      n += int'(full);
    end
    for (int x = 0; x < 5; x++) begin
      full = 1;
      for (int y = 0; y < 5; y++) if (!c[x + 5*y]) full = 0;
      n += int'(full);
    end
    full = 1;
    for (int i = 0; i < 5; i++) if (!c[i + 5*i]) full = 0;
    n += int'(full);
    full = 1;
    for (int i = 0; i < 5; i++) if (!c[(4 - i) + 5*i]) full = 0;
    n += int'(full);
    return n;
  endfunction

  task automatic load_map;
    for (int i = 0; i < 25; i++) map[i*CW +: CW] = CW'(m_map[i]);
  endtask

  task automatic wait_ready;
    int t;
    t = 0;
    while (!mark_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!mark_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: mark_ready still 0 after %0d cycles, expected 1", t);
    end
  endtask

  // Issue one request, update the model and queue the expected result.
  task automatic do_mark(input int n);
    exp_t e;
    int   k;
    int   cnt;
    wait_ready();
    mark_num   = CW'(n);
    mark_valid = 1'b1;
    @(posedge clk);
    #1;
    e.acc_cyc  = cyc;
    mark_valid = 1'b0;
    k = -1;
    for (int i = 0; i < 25; i++)
      if (k < 0 && m_map[i] == n) k = i;
    if (k >= 0) m_circle[k] = 1'b1;
    cnt    = count_lines(m_circle);
    e.hit  = (k >= 0);
    e.circ = m_circle;
    e.cnt  = 4'(cnt);
    e.disp = 8'((cnt / 10) * 16 + (cnt % 10));
    e.bng  = (cnt >= BL);
    e.lat  = (k >= 0) ? k + 14 : 38;
    exp_q.push_back(e);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && mark_done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: mark_done=1 with no pending request (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_latency", 32'(cyc - e.acc_cyc + 1), 32'(e.lat));
        check("mark_hit", {31'd0, mark_hit}, {31'd0, e.hit});
        check("circle", {7'd0, circle}, {7'd0, e.circ});
        check("line_cnt", {28'd0, line_cnt}, {28'd0, e.cnt});
        check("display_nums", {24'd0, display_nums}, {24'd0, e.disp});
        check("bingo", {31'd0, bingo}, {31'd0, e.bng});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int dones;
    int n;
    rst        = 1'b1;
    clear      = 1'b0;
    mark_valid = 1'b0;
    mark_num   = '0;
    for (int i = 0; i < 25; i++) m_map[i] = i + 1;
    load_map();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_circle", {7'd0, circle}, 32'd0);
    check("rst_ready", {31'd0, mark_ready}, 32'd1);
    check("rst_line_cnt", {28'd0, line_cnt}, 32'd0);

    // Reset mid-SCAN: the request is discarded, no mark_done follows
    mark_num   = CW'(20);
    mark_valid = 1'b1;
    @(negedge clk);
    mark_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("scan_busy_ready", {31'd0, mark_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_circle", {7'd0, circle}, 32'd0);
    check("midrst_line_cnt", {28'd0, line_cnt}, 32'd0);
    check("midrst_display", {24'd0, display_nums}, 32'd0);
    check("midrst_ready", {31'd0, mark_ready}, 32'd1);
    rst   = 1'b0;
    dones = 0;
    repeat (45) begin
      @(negedge clk);
      if (mark_done) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);

    // Single mark, then a full first row, then a repeat
    do_mark(1);
    for (int v = 2; v <= 5; v++) do_mark(v);
    do_mark(1);

    // Unmatchable numbers, with a request held while busy
    do_mark(0);
    do_mark(30);
    @(negedge clk);
    mark_num   = CW'(3);
    mark_valid = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("busy_ready", {31'd0, mark_ready}, 32'd0);
    end
    mark_valid = 1'b0;

    // Whole board, then clear together with a request
    for (int v = 1; v <= 25; v++) do_mark(v);
    wait_ready();
    @(negedge clk);
    clear      = 1'b1;
    mark_valid = 1'b1;
    mark_num   = CW'(7);
    @(posedge clk);
    #1;
    clear      = 1'b0;
    mark_valid = 1'b0;
    m_circle   = '0;
    @(negedge clk);
    check("clr_circle", {7'd0, circle}, 32'd0);
    check("clr_line_cnt", {28'd0, line_cnt}, 32'd0);
    check("clr_display", {24'd0, display_nums}, 32'd0);
    check("clr_bingo", {31'd0, bingo}, 32'd0);
    check("clr_hit", {31'd0, mark_hit}, 32'd0);
    check("clr_ready", {31'd0, mark_ready}, 32'd1);

    // Both diagonals sharing the centre cell
    do_mark(1); do_mark(7); do_mark(13); do_mark(19); do_mark(25);
    do_mark(5); do_mark(9); do_mark(17); do_mark(21);

    // Randomized board with duplicates and random requests
    wait_ready();
    @(negedge clk);
    clear = 1'b1;
    for (int i = 0; i < 25; i++) m_map[i] = int'($urandom_range(1, 25));
    load_map();
    @(negedge clk);
    clear    = 1'b0;
    m_circle = '0;
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 3) != 0) n = m_map[$urandom_range(0, 24)];
      else n = int'($urandom_range(0, 31));
      do_mark(n);
    end

    wait_ready();
    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
